// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, limits and helpers for the buffered UART transmitter
// Contents: parity_mode_e, uart_tx_state_e, data-length limits,
//           clamp_data_bits(), has_parity(), parity_bit().
package uart_pkg;

  localparam int UART_MIN_DATA_BITS = 5;
  localparam int UART_MAX_DATA_BITS = 9;

  // Encodings 5..7 are not listed; they behave as PAR_NONE.
  typedef enum logic [2:0] {
    PAR_NONE  = 3'd0,
    PAR_EVEN  = 3'd1,
    PAR_ODD   = 3'd2,
    PAR_MARK  = 3'd3,
    PAR_SPACE = 3'd4
  } parity_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2,
    ST_BRK
  } uart_tx_state_e;

  function automatic logic [3:0] clamp_data_bits(input logic [3:0] req,
                                                 input logic [3:0] max_bits);
    if (req < 4'(UART_MIN_DATA_BITS)) return 4'(UART_MIN_DATA_BITS);
    if (req > max_bits) return max_bits;
    return req;
  endfunction

  function automatic logic has_parity(input logic [2:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD) ||
           (mode == PAR_MARK) || (mode == PAR_SPACE);
  endfunction

  // acc is the XOR of the data bits actually sent.
  function automatic logic parity_bit(input logic [2:0] mode, input logic acc);
    case (mode)
      PAR_EVEN: return acc;
      PAR_ODD:  return ~acc;
      PAR_MARK: return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - synchronous FIFO with flush, registered occupancy
// Ports: clk, arst_n (async active-low), push/push_data (ignored when full),
//        pop (ignored when empty), pop_data (head word, valid when !empty),
//        flush (clears next cycle, wins over push/pop), full, empty, level.
module uart_sync_fifo
#(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       arst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == LW'(DEPTH));
  assign empty    = (count == '0);
  assign level    = count;
  assign pop_data = mem[rd_ptr];

  // Push is refused when full even if a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered UART transmitter: stream-fed FIFO plus frame serialiser
// Optional feature macro: UART_TX_BREAK_EN (line break generation via break_req).
// Ports: clk, arst_n (async active-low); active (gates frame starts), tick (baud enable);
//        data_bits/parity_mode/stop_bits (frame config, latched at frame start);
//        s_valid/s_data/s_ready (word stream in), flush (FIFO clear), break_req;
//        tx (serial out, idle high), busy, frame_done (pulse), fifo_level.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W      = 9,
  parameter int FIFO_DEPTH  = 8,
  parameter int BREAK_TICKS = 13
) (
  input  logic                          clk,
  input  logic                          arst_n,
  input  logic                          active,
  input  logic                          tick,
  input  logic [3:0]                    data_bits,
  input  logic [2:0]                    parity_mode,
  input  logic                          stop_bits,
  input  logic                          s_valid,
  input  logic [DATA_W-1:0]             s_data,
  output logic                          s_ready,
  input  logic                          flush,
  input  logic                          break_req,
  output logic                          tx,
  output logic                          busy,
  output logic                          frame_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam logic [3:0] MAX_BITS = 4'(DATA_W);

  uart_tx_state_e    state;
  logic [DATA_W-1:0] shreg;
  logic              par_acc;
  logic [3:0]        bit_cnt;
  logic [3:0]        cfg_bits;
  logic [2:0]        cfg_par;
  logic              cfg_stop;

  logic [DATA_W-1:0] head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              can_start;
  logic              idle_start;
  logic              frame_end;
  logic              seq_end;
  logic              pop;

  uart_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .arst_n    (arst_n),
    .push      (s_valid),
    .push_data (s_data),
    .pop       (pop),
    .flush     (flush),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign s_ready   = !fifo_full;
  assign can_start = active && !fifo_empty;

`ifdef UART_TX_BREAK_EN
  localparam int             BW           = $clog2(BREAK_TICKS + 1);
  localparam logic [BW-1:0]  BRK_LAST_LOW = BW'(BREAK_TICKS - 1);
  localparam logic [BW-1:0]  BRK_STOP     = BW'(BREAK_TICKS);

  logic [BW-1:0] brk_cnt;
  logic          brk_end;

  // brk_cnt == BRK_STOP marks the single high period after the low run.
  assign brk_end = tick && (state == ST_BRK) && (brk_cnt == BRK_STOP);
`else
  logic [32:0] unused_break;
  assign unused_break = {break_req, 32'(BREAK_TICKS)};
`endif

  // Tick-qualified decisions shared by the FIFO pop and the state register.
  always_comb begin
    idle_start = 1'b0;
    frame_end  = 1'b0;
    if (tick) begin
      case (state)
`ifdef UART_TX_BREAK_EN
        ST_IDLE:  idle_start = !break_req;
`else
        ST_IDLE:  idle_start = 1'b1;
`endif
        ST_STOP1: frame_end  = !cfg_stop;
        ST_STOP2: frame_end  = 1'b1;
        default:  ;
      endcase
    end
  end

`ifdef UART_TX_BREAK_EN
  assign seq_end = frame_end || brk_end;
`else
  assign seq_end = frame_end;
`endif

  // A new frame may start from IDLE or directly on the last stop tick,
  // which is what makes back-to-back frames gapless.
  assign pop = can_start && (idle_start || seq_end);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state      <= ST_IDLE;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      shreg      <= '0;
      par_acc    <= 1'b0;
      bit_cnt    <= '0;
      cfg_bits   <= '0;
      cfg_par    <= '0;
      cfg_stop   <= 1'b0;
`ifdef UART_TX_BREAK_EN
      brk_cnt    <= '0;
`endif
    end else begin
      frame_done <= frame_end;
      if (pop) begin
        state    <= ST_DATA;
        busy     <= 1'b1;
        tx       <= 1'b0;
        shreg    <= head;
        par_acc  <= 1'b0;
        bit_cnt  <= '0;
        cfg_bits <= clamp_data_bits(data_bits, MAX_BITS);
        cfg_par  <= parity_mode;
        cfg_stop <= stop_bits;
      end else if (seq_end) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
        tx    <= 1'b1;
      end else if (tick) begin
        case (state)
`ifdef UART_TX_BREAK_EN
          ST_IDLE: begin
            if (break_req) begin
              state   <= ST_BRK;
              busy    <= 1'b1;
              tx      <= 1'b0;
              brk_cnt <= '0;
            end
          end
          ST_BRK: begin
            brk_cnt <= brk_cnt + BW'(1);
            if (brk_cnt == BRK_LAST_LOW) tx <= 1'b1;
          end
`endif
          ST_DATA: begin
            if (bit_cnt != cfg_bits) begin
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
              par_acc <= par_acc ^ shreg[0];
              bit_cnt <= bit_cnt + 4'd1;
            end else if (has_parity(cfg_par)) begin
              state <= ST_PARITY;
              tx    <= parity_bit(cfg_par, par_acc);
            end else begin
              state <= ST_STOP1;
              tx    <= 1'b1;
            end
          end
          ST_PARITY: begin
            state <= ST_STOP1;
            tx    <= 1'b1;
          end
          // Only reached with two stop bits; one stop bit ends via seq_end.
          ST_STOP1: begin
            state <= ST_STOP2;
            tx    <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - randomized self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

  localparam int DATA_W      = 9;
  localparam int FIFO_DEPTH  = 8;
  localparam int BREAK_TICKS = 13;
  localparam int LW          = $clog2(FIFO_DEPTH) + 1;

  logic              clk = 1'b0;
  logic              arst_n = 1'b0;
  logic              active = 1'b0;
  logic              tick = 1'b0;
  logic [3:0]        data_bits = 4'd8;
  logic [2:0]        parity_mode = 3'd0;
  logic              stop_bits = 1'b0;
  logic              s_valid = 1'b0;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_ready;
  logic              flush = 1'b0;
  logic              break_req = 1'b0;
  logic              tx;
  logic              busy;
  logic              frame_done;
  logic [LW-1:0]     fifo_level;

  uart_tx_fifo #(
    .DATA_W      (DATA_W),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .BREAK_TICKS (BREAK_TICKS)
  ) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .active      (active),
    .tick        (tick),
    .data_bits   (data_bits),
    .parity_mode (parity_mode),
    .stop_bits   (stop_bits),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .flush       (flush),
    .break_req   (break_req),
    .tx          (tx),
    .busy        (busy),
    .frame_done  (frame_done),
    .fifo_level  (fifo_level)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Baud tick: one cycle high every tick_div clocks.
  int tick_div = 4;
  int tick_cnt = 0;
  initial forever begin
    @(negedge clk);
    tick_cnt++;
    if (tick_cnt >= tick_div) begin
      tick     = 1'b1;
      tick_cnt = 0;
    end else begin
      tick = 1'b0;
    end
  end

  int   cyc = 0;
  logic tick_q = 1'b0;
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    tick_q <= tick;
  end

  // Reference model: queue of accepted words with the config in force when pushed.
  typedef struct {
    logic [DATA_W-1:0] w;
    int nb;
    int pm;
    int sb;
  } frm_t;

  frm_t model_q[$];
  bit   exp_bits[$];
  bit   obs_log[$];
  bit   mon_en = 1'b0;
  bit   ended = 1'b0;
  int   start_cyc = 0;
  int   frame_periods = 0;
  int   fd_count = 0;
  frm_t cur;
  bit   exp_b;
  bit   par;
  int   nbits;

  // Samples tx once per bit period, just after the tick edge.
  always @(negedge clk) begin
    if (frame_done) fd_count++;
    if (mon_en && tick_q) begin
      if (exp_bits.size() > 0) begin
        exp_b = exp_bits.pop_front();
        obs_log.push_back(tx);
        check_eq("tx_bit", tx, exp_b);
        if (exp_bits.size() == 0) begin
          check_eq("busy_last_stop", busy, 1);
          ended = 1'b1;
        end
      end else begin
        if (ended) begin
          check_eq("frame_len", cyc - start_cyc, frame_periods * tick_div);
          if (model_q.size() > 0 && active) check_eq("no_gap", tx, 0);
          else check_eq("busy_end", busy, 0);
          ended = 1'b0;
        end
        if (tx == 1'b0) begin
          if (model_q.size() == 0) begin
            check_eq("spurious_start", tx, 1);
          end else begin
            cur = model_q.pop_front();
            obs_log.push_back(tx);
            check_eq("level_at_start", fifo_level, model_q.size());
            nbits = (cur.nb < 5) ? 5 : ((cur.nb > DATA_W) ? DATA_W : cur.nb);
            par = 1'b0;
            for (int i = 0; i < nbits; i++) begin
              exp_bits.push_back(cur.w[i]);
              par = par ^ cur.w[i];
            end
            case (cur.pm)
              1: exp_bits.push_back(par);
              2: exp_bits.push_back(!par);
              3: exp_bits.push_back(1'b1);
              4: exp_bits.push_back(1'b0);
              default: ;
            endcase
            exp_bits.push_back(1'b1);
            if (cur.sb != 0) exp_bits.push_back(1'b1);
            frame_periods = 1 + exp_bits.size();
            start_cyc = cyc;
          end
        end
      end
    end
  end

  logic [DATA_W-1:0] bw[8];

  task automatic setup(input int nb, input int pm, input int sb, input int div);
    @(negedge clk);
    active      = 1'b0;
    data_bits   = 4'(nb);
    parity_mode = 3'(pm);
    stop_bits   = (sb != 0);
    tick_div    = div;
  endtask

  // Called at a negedge; consecutive calls push back-to-back.
  task automatic push_word(input logic [DATA_W-1:0] w);
    frm_t f;
    s_data  = w;
    s_valid = 1'b1;
    f.w = w; f.nb = int'(data_bits); f.pm = int'(parity_mode); f.sb = int'(stop_bits);
    model_q.push_back(f);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic drain(input int n, input int fd0);
    int budget;
    bit done;
    budget = n * 16 * tick_div + 40 * tick_div + 100;
    done = 1'b0;
    active = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (model_q.size() == 0 && exp_bits.size() == 0 && !ended && !busy) begin
        done = 1'b1;
        break;
      end
    end
    @(negedge clk);
    check_eq("drain_done", done, 1);
    check_eq("frames_done", fd_count - fd0, n);
    check_eq("level_end", fifo_level, 0);
    check_eq("tx_idle", tx, 1);
    active = 1'b0;
  endtask

  task automatic run_batch(input int nb, input int pm, input int sb, input int div, input int n);
    int fd0;
    setup(nb, pm, sb, div);
    fd0 = fd_count;
    obs_log.delete();
    for (int i = 0; i < n; i++) push_word(bw[i]);
    drain(n, fd0);
  endtask

  task automatic wait_tick_sample();
    do @(negedge clk); while (!tick_q);
  endtask

  function automatic logic [31:0] log_value();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < obs_log.size() && i < 32; i++) v[i] = obs_log[i];
    return v;
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int fd0;
    bit stayed_high;
    bit seen;
    logic [31:0] brk_vec;

    repeat (3) @(negedge clk);
    check_eq("rst_tx", tx, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_frame_done", frame_done, 0);
    check_eq("rst_s_ready", s_ready, 1);
    check_eq("rst_level", fifo_level, 0);
    arst_n = 1'b1;
    mon_en = 1'b1;

    // 8N1, 0xA5, 16 clocks per bit
    bw[0] = 9'h0A5;
    run_batch(8, 0, 0, 16, 1);
    check_eq("t1_len", obs_log.size(), 10);
    check_eq("t1_seq", log_value(), 32'h34A);

    // 7E2, 0x7F
    bw[0] = 9'h07F;
    run_batch(7, 1, 1, 4, 1);
    check_eq("t2_len", obs_log.size(), 11);
    check_eq("t2_seq", log_value(), 32'h7FE);

    // 5O1, 0x1E0: upper bits never sent
    bw[0] = 9'h1E0;
    run_batch(5, 2, 0, 4, 1);
    check_eq("t3_len", obs_log.size(), 8);
    check_eq("t3_seq", log_value(), 32'h0C0);

    // Fill FIFO, overflow attempt, then gapless drain
    setup(8, 0, 0, 2);
    fd0 = fd_count;
    for (int i = 0; i < FIFO_DEPTH; i++) push_word(DATA_W'($urandom));
    check_eq("t4_s_ready_full", s_ready, 0);
    check_eq("t4_level_full", fifo_level, FIFO_DEPTH);
    s_data  = 9'h1FF;
    s_valid = 1'b1;
    repeat (3) @(negedge clk);
    s_valid = 1'b0;
    check_eq("t4_level_overflow", fifo_level, FIFO_DEPTH);
    drain(FIFO_DEPTH, fd0);

    // Flush wins over a simultaneous push
    setup(8, 0, 0, 4);
    for (int i = 0; i < 3; i++) push_word(DATA_W'(i + 1));
    model_q.delete();
    check_eq("flush_level_before", fifo_level, 3);
    flush   = 1'b1;
    s_valid = 1'b1;
    s_data  = 9'h055;
    @(negedge clk);
    flush   = 1'b0;
    s_valid = 1'b0;
    check_eq("flush_level_after", fifo_level, 0);
    check_eq("flush_s_ready", s_ready, 1);

    // Randomized batches: config, divider and words drawn per batch
    for (int b = 0; b < 10; b++) begin
      int nb, pm, sb, div, n;
      nb  = $urandom_range(0, 15);
      pm  = $urandom_range(0, 7);
      sb  = $urandom_range(0, 1);
      div = $urandom_range(1, 4);
      n   = $urandom_range(1, FIFO_DEPTH);
      for (int i = 0; i < n; i++) bw[i] = DATA_W'($urandom);
      run_batch(nb, pm, sb, div, n);
    end

    // Reset during the 4th data bit of a 9-bit mark-parity frame
    mon_en = 1'b0;
    setup(9, 3, 0, 4);
    push_word(9'h155);
    push_word(9'h0AA);
    model_q.delete();
    active = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (tick_q && !tx) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("t5_start_seen", seen, 1);
    for (int k = 0; k < 4; k++) wait_tick_sample();
    @(posedge clk);
    #2 arst_n = 1'b0;
    #1;
    check_eq("t5_async_tx", tx, 1);
    check_eq("t5_async_level", fifo_level, 0);
    check_eq("t5_async_busy", busy, 0);
    @(negedge clk);
    arst_n = 1'b1;
    stayed_high = 1'b1;
    for (int k = 0; k < 20; k++) begin
      wait_tick_sample();
      if (tx !== 1'b1 || busy !== 1'b0) stayed_high = 1'b0;
    end
    check_eq("t5_no_residual", stayed_high, 1);
    active = 1'b0;
    exp_bits.delete();
    ended = 1'b0;

`ifdef UART_TX_BREAK_EN
    // Break with one word queued: 13 low, 1 high, then the data frame
    setup(8, 0, 0, 2);
    push_word(9'h00F);
    model_q.delete();
    fd0 = fd_count;
    break_req = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (tick_q && !tx) begin
        seen = 1'b1;
        break;
      end
    end
    break_req = 1'b0;
    active = 1'b1;
    check_eq("t6_break_seen", seen, 1);
    brk_vec = '0;
    for (int k = 0; k < BREAK_TICKS + 1; k++) begin
      wait_tick_sample();
      brk_vec[k] = tx;
    end
    check_eq("t6_break_shape", brk_vec, 32'(1) << (BREAK_TICKS - 1));
    check_eq("t6_break_fd", fd_count - fd0, 0);
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!busy) begin
        seen = 1'b1;
        break;
      end
    end
    @(negedge clk);
    check_eq("t6_frame_end", seen, 1);
    check_eq("t6_frame_fd", fd_count - fd0, 1);
    active = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
